// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - opcode encodings, arithmetic-unit FSM states and step-count helper
package alu_defs;

    localparam logic [2:0] ARITH_ADD = 3'd0;
    localparam logic [2:0] ARITH_SUB = 3'd1;
    localparam logic [2:0] ARITH_MOD = 3'd2;
    localparam logic [2:0] ARITH_EXP = 3'd3;
    localparam logic [2:0] AND_      = 3'd4;
    localparam logic [2:0] OR_       = 3'd5;
    localparam logic [2:0] MOV_      = 3'd6;

    typedef enum logic [2:0] {IDLE, REDUCE, MUL, SQR, FINISH} au_state_t;

    // One multiplier bit is consumed per cycle.
    function automatic int au_mulsteps(input int width);
        return width;
    endfunction

endpackage

// File: rtl/rsa_modmul.sv
// rtl/rsa_modmul.sv - iterative (x*y) mod m, MSB-first interleaved shift-add, WIDTH cycles
module rsa_modmul
    import alu_defs::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] m,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int STEPS = au_mulsteps(WIDTH);
    localparam int CW = $clog2(STEPS);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    logic             active;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] yq;
    logic [WIDTH-1:0] mq;
    logic [WIDTH+1:0] r;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] t0;
    logic [WIDTH+1:0] t1;
    logic [WIDTH+1:0] t2;

    // r < m, so 2r + y < 3m: two conditional subtracts restore r < m.
    always_comb begin
        m_ext = {2'b00, mq};
        t0    = (r << 1) + (xs[WIDTH-1] ? {2'b00, yq} : '0);
        t1    = (t0 >= m_ext) ? t0 - m_ext : t0;
        t2    = (t1 >= m_ext) ? t1 - m_ext : t1;
    end

    // done is combinational in the last step so the caller can chain a new start on the same edge.
    assign done   = active && (cnt == LAST);
    assign result = t2[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            xs     <= '0;
            yq     <= '0;
            mq     <= '0;
            r      <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            xs     <= x;
            yq     <= y;
            mq     <= m;
            r      <= '0;
        end else if (active) begin
            r   <= t2;
            xs  <= xs << 1;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) active <= 1'b0;
        end
    end

endmodule

// File: rtl/rsa_arith_unit.sv
// rtl/rsa_arith_unit.sv - multi-cycle ADD/SUB/MOD/EXP unit; ARITH_LOGIC_OPS_EN adds AND_/OR_/MOV_
module rsa_arith_unit
    import alu_defs::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(ARITH_ADD);
    localparam logic [OPW-1:0] OP_SUB = OPW'(ARITH_SUB);
    localparam logic [OPW-1:0] OP_MOD = OPW'(ARITH_MOD);
    localparam logic [OPW-1:0] OP_EXP = OPW'(ARITH_EXP);
`ifdef ARITH_LOGIC_OPS_EN
    localparam logic [OPW-1:0] OP_AND = OPW'(AND_);
    localparam logic [OPW-1:0] OP_OR  = OPW'(OR_);
    localparam logic [OPW-1:0] OP_MOV = OPW'(MOV_);
`endif

    au_state_t        state, state_d;
    logic [WIDTH-1:0] e, e_d, base, base_d, acc, acc_d, m_q, m_d, a_sh, a_sh_d;
    logic [WIDTH:0]   rem, rem_d, rem_shift, rem_nxt, m_ext, sum, diff;
    logic [CW-1:0]    cnt, cnt_d;
    logic             exp_q, exp_d, carry_q, carry_d, err_q, err_d, busy_d;
    logic [WIDTH-1:0] res_q, res_d, acc_init;
    logic             mm_start, mm_done;
    logic [WIDTH-1:0] mm_x, mm_y, mm_res;

    rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mm_start),
        .x      (mm_x),
        .y      (mm_y),
        .m      (m_q),
        .done   (mm_done),
        .result (mm_res)
    );

    always_comb begin
        state_d  = state;
        e_d      = e;
        base_d   = base;
        acc_d    = acc;
        m_d      = m_q;
        a_sh_d   = a_sh;
        rem_d    = rem;
        cnt_d    = cnt;
        exp_d    = exp_q;
        res_d    = res_q;
        carry_d  = carry_q;
        err_d    = err_q;
        mm_start = 1'b0;
        mm_x     = base;
        mm_y     = base;
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        acc_init  = (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
        m_ext     = {1'b0, m_q};
        rem_shift = (rem << 1) | {{WIDTH{1'b0}}, a_sh[WIDTH-1]};
        rem_nxt   = (rem_shift >= m_ext) ? rem_shift - m_ext : rem_shift;
        case (state)
            IDLE: begin
                if (start && !busy) begin
                    m_d     = m;
                    e_d     = b;
                    a_sh_d  = a;
                    rem_d   = '0;
                    cnt_d   = '0;
                    exp_d   = (op == OP_EXP);
                    res_d   = '0;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = FINISH;
                    case (op)
                        OP_ADD: {carry_d, res_d} = sum;
                        OP_SUB: {carry_d, res_d} = diff;
                        OP_MOD, OP_EXP: begin
                            if (m == '0) err_d = 1'b1;
                            else         state_d = REDUCE;
                        end
`ifdef ARITH_LOGIC_OPS_EN
                        OP_AND: res_d = a & b;
                        OP_OR:  res_d = a | b;
                        OP_MOV: res_d = b;
`endif
                        default: err_d = 1'b1;
                    endcase
                end
            end
            REDUCE: begin
                a_sh_d = a_sh << 1;
                rem_d  = rem_nxt;
                cnt_d  = cnt + 1'b1;
                if (cnt == LAST) begin
                    base_d = rem_nxt[WIDTH-1:0];
                    if (!exp_q) begin
                        res_d   = rem_nxt[WIDTH-1:0];
                        state_d = FINISH;
                    end else begin
                        acc_d = acc_init;
                        if (e == '0) begin
                            res_d   = acc_init;
                            state_d = FINISH;
                        end else begin
                            mm_start = 1'b1;
                            mm_x     = e[0] ? acc_init : rem_nxt[WIDTH-1:0];
                            mm_y     = rem_nxt[WIDTH-1:0];
                            state_d  = e[0] ? MUL : SQR;
                        end
                    end
                end
            end
            MUL: begin
                if (mm_done) begin
                    acc_d = mm_res;
                    // Skip the trailing square once no exponent bits remain.
                    if (e[WIDTH-1:1] == '0) begin
                        res_d   = mm_res;
                        state_d = FINISH;
                    end else begin
                        mm_start = 1'b1;
                        state_d  = SQR;
                    end
                end
            end
            SQR: begin
                if (mm_done) begin
                    base_d = mm_res;
                    e_d    = e >> 1;
                    if (e[WIDTH-1:1] == '0) begin
                        res_d   = acc;
                        state_d = FINISH;
                    end else begin
                        mm_start = 1'b1;
                        mm_x     = e[1] ? acc : mm_res;
                        mm_y     = mm_res;
                        state_d  = e[1] ? MUL : SQR;
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            e       <= '0;
            base    <= '0;
            acc     <= '0;
            m_q     <= '0;
            a_sh    <= '0;
            rem     <= '0;
            cnt     <= '0;
            exp_q   <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            e       <= e_d;
            base    <= base_d;
            acc     <= acc_d;
            m_q     <= m_d;
            a_sh    <= a_sh_d;
            rem     <= rem_d;
            cnt     <= cnt_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            busy    <= busy_d;
            done    <= (state == FINISH);
            if (state == FINISH) begin
                result <= res_q;
                carry  <= carry_q;
                err    <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_rsa_arith_unit.sv
// tb/tb_rsa_arith_unit.sv - scoreboard bench for rsa_arith_unit, WIDTH=16
module tb_rsa_arith_unit;
    import alu_defs::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0, b = '0, m = '0;
    logic         busy, done, carry, err;
    logic [W-1:0] result;

    rsa_arith_unit #(.WIDTH(W), .OPW(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .m      (m),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .err    (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic drive_in_done;

    typedef struct {
        string        name;
        logic [W-1:0] res;
        logic         carry;
        logic         err;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Waits for an idle (or done) cycle, drives one start pulse, optionally records the expectation.
    task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] im, input logic [W-1:0] eres, input logic ecarry, input logic eerr,
                         input int elat, input bit track);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            check({name, "_idle_timeout"}, busy, 0);
        end else begin
            drive_in_done = done;
            op = o; a = ia; b = ib; m = im; start = 1'b1;
            if (track) begin
                exp_t ex;
                ex.name = name; ex.res = eres; ex.carry = ecarry; ex.err = eerr; ex.lat = elat; ex.t0 = cyc;
                sb.push_back(ex);
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: result 0x%0h with no operation outstanding", result);
            end else begin
                exp_t ex;
                ex = sb.pop_front();
                check({ex.name, "_result"}, result, ex.res);
                check({ex.name, "_carry"}, carry, ex.carry);
                check({ex.name, "_err"}, err, ex.err);
                check({ex.name, "_latency"}, cyc - ex.t0, ex.lat);
                check({ex.name, "_busy_low"}, busy, 0);
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        issue("add_wrap", ARITH_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 2, 1);
        issue("sub_borrow", ARITH_SUB, 16'd3, 16'd5, 16'h0000, 16'hFFFE, 1'b1, 1'b0, 2, 1);
        issue("mod_1000_7", ARITH_MOD, 16'd1000, 16'd0, 16'd7, 16'd6, 1'b0, 1'b0, 18, 1);
        issue("mod_m0", ARITH_MOD, 16'd5, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 2, 1);

        issue("exp_4_13_497", ARITH_EXP, 16'd4, 16'd13, 16'd497, 16'd445, 1'b0, 1'b0, 114, 1);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; op = ARITH_ADD; a = 16'd1 + 16'(i); b = 16'd2; m = 16'd3;
            @(negedge clk);
        end
        start = 1'b0; a = 16'hBEEF; b = 16'h0007; m = 16'd11;

        issue("exp_b0_m1", ARITH_EXP, 16'd9, 16'd0, 16'd1, 16'd0, 1'b0, 1'b0, 18, 1);
        issue("exp_b0_m10", ARITH_EXP, 16'd9, 16'd0, 16'd10, 16'd1, 1'b0, 1'b0, 18, 1);
        issue("exp_600_2_7", ARITH_EXP, 16'd600, 16'd2, 16'd7, 16'd4, 1'b0, 1'b0, 50, 1);

        issue("b2b_mod", ARITH_MOD, 16'd1000, 16'd0, 16'd7, 16'd6, 1'b0, 1'b0, 18, 1);
        issue("b2b_add", ARITH_ADD, 16'h1234, 16'h0001, 16'h0000, 16'h1235, 1'b0, 1'b0, 2, 1);
        check("b2b_start_in_done_cycle", drive_in_done, 1);
        check("b2b_busy_held", busy, 1);

`ifdef ARITH_LOGIC_OPS_EN
        issue("and_op", AND_, 16'hF0F0, 16'h0FF0, 16'h0000, 16'h00F0, 1'b0, 1'b0, 2, 1);
`else
        issue("and_op", AND_, 16'hF0F0, 16'h0FF0, 16'h0000, 16'h0000, 1'b0, 1'b1, 2, 1);
`endif
        issue("bad_op", 3'd7, 16'h1111, 16'h2222, 16'd5, 16'h0000, 1'b0, 1'b1, 2, 1);
        issue("exp_3_5_7", ARITH_EXP, 16'd3, 16'd5, 16'd7, 16'd5, 1'b0, 1'b0, 82, 1);

        issue("exp_abort", ARITH_EXP, 16'd4, 16'd13, 16'd497, 16'd0, 1'b0, 1'b0, 0, 0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue("mod_after_rst", ARITH_MOD, 16'd100, 16'd0, 16'd9, 16'd1, 1'b0, 1'b0, 18, 1);

        guard = 0;
        while (sb.size() != 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
